// File: rtl/reg_writeback_queue.sv
// Write-back queue: forms register writes per opcode, buffers them in order,
// drains one per cycle into the register file and forwards pending results.
module reg_writeback_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [5:0]                 in_opcode,
  input  logic [4:0]                 in_rt,
  input  logic [4:0]                 in_rd,
  input  logic                       in_rt_rd,
  input  logic                       in_mem_sel,
  input  logic [31:0]                in_alu,
  input  logic [31:0]                in_mem,
  input  logic [31:0]                in_pc,
  input  logic [15:0]                in_imm,
  input  logic                       wr_ready,
  output logic                       wr_en,
  output logic [4:0]                 wr_addr,
  output logic [31:0]                wr_data,
  output logic [3:0]                 wr_mask,
  input  logic [4:0]                 fwd_addr,
  output logic                       fwd_hit,
  output logic                       fwd_partial,
  output logic [31:0]                fwd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;

  logic [4:0]    q_addr [DEPTH];
  logic [31:0]   q_data [DEPTH];
  logic [3:0]    q_mask [DEPTH];
  logic [PW-1:0] head, tail;

  logic [4:0]  new_addr;
  logic [31:0] new_data;
  logic [3:0]  new_mask;
  logic        accept, push, pop;

  // Handshakes: input transfers at posedge when in_valid && in_ready; output
  // transfers at posedge when wr_en && wr_ready. in_ready never looks at wr_ready.
  assign in_ready = !reset && (count < FULL);
  assign accept   = in_valid && in_ready;
  assign push     = accept && (new_addr != 5'd0);
  assign wr_en    = (count != '0);
  assign pop      = wr_en && wr_ready;

  assign wr_addr = q_addr[head];
  assign wr_data = q_data[head];
  assign wr_mask = q_mask[head];

  always_comb begin
    new_addr = in_rt_rd ? in_rt : in_rd;
    new_data = in_mem_sel ? in_mem : in_alu;
    new_mask = 4'b1111;
    case (in_opcode)
      OP_LB: begin
        new_addr = in_rt;
        new_data = {24'h0, in_mem[7:0]};
        new_mask = 4'b0001;
      end
      OP_LH: begin
        new_addr = in_rt;
        new_data = {16'h0, in_mem[15:0]};
        new_mask = 4'b0011;
      end
      OP_LUI: begin
        new_addr = in_rt;
        new_data = {in_imm, 16'h0};
      end
      OP_JAL: begin
        new_addr = 5'd31;
        new_data = in_pc + 32'd4;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= new_addr;
      q_data[tail] <= new_data;
      q_mask[tail] <= new_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Walk oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    fwd_hit     = 1'b0;
    fwd_partial = 1'b0;
    fwd_data    = 32'h0;
    if (fwd_addr != 5'd0) begin
      for (int i = 0; i < DEPTH; i++) begin
        idx = head + PW'(i);
        if ((CW'(i) < count) && (q_addr[idx] == fwd_addr)) begin
          fwd_hit     = 1'b1;
          fwd_partial = (q_mask[idx] != 4'b1111);
          fwd_data    = q_data[idx];
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: opcode formation, ordering,
// backpressure, forwarding, address-zero drop and mid-run reset.
module tb_reg_writeback_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [4:0]  in_rt, in_rd;
  logic        in_rt_rd, in_mem_sel;
  logic [31:0] in_alu, in_mem, in_pc;
  logic [15:0] in_imm;
  logic        wr_ready;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_mask;
  logic [4:0]  fwd_addr;
  logic        fwd_hit, fwd_partial;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LUI = 6'b001111;
  localparam logic [5:0] OP_JAL = 6'b000011;

  reg_writeback_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rt(in_rt), .in_rd(in_rd), .in_rt_rd(in_rt_rd),
    .in_mem_sel(in_mem_sel), .in_alu(in_alu), .in_mem(in_mem), .in_pc(in_pc),
    .in_imm(in_imm), .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_mask(wr_mask), .fwd_addr(fwd_addr), .fwd_hit(fwd_hit),
    .fwd_partial(fwd_partial), .fwd_data(fwd_data), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // driver: presents one result at a negedge, holds it across one posedge
  task automatic push_one(input logic [5:0] op, input logic [4:0] rt, input logic [4:0] rd,
                          input logic rt_rd, input logic mem_sel, input logic [31:0] alu,
                          input logic [31:0] mem, input logic [31:0] pc, input logic [15:0] imm);
    in_valid   = 1'b1;
    in_opcode  = op;
    in_rt      = rt;
    in_rd      = rd;
    in_rt_rd   = rt_rd;
    in_mem_sel = mem_sel;
    in_alu     = alu;
    in_mem     = mem;
    in_pc      = pc;
    in_imm     = imm;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [4:0] a, input logic [31:0] d,
                            input logic [3:0] m);
    check({tag, ".wr_en"},   32'(wr_en), 32'd1);
    check({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
    check({tag, ".wr_data"}, wr_data, d);
    check({tag, ".wr_mask"}, 32'(wr_mask), 32'(m));
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_opcode = '0; in_rt = '0; in_rd = '0;
    in_rt_rd = 1'b0; in_mem_sel = 1'b0; in_alu = '0; in_mem = '0; in_pc = '0;
    in_imm = '0; wr_ready = 1'b1; fwd_addr = 5'd0;

    @(negedge clk); @(negedge clk); #1;
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.count", 32'(count), 32'd0);
    check("rst.wr_en", 32'(wr_en), 32'd0);
    check("rst.fwd_hit", 32'(fwd_hit), 32'd0);
    check("rst.fwd_partial", 32'(fwd_partial), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst.in_ready", 32'(in_ready), 32'd1);

    // single add to r5
    push_one(OP_R, 5'd0, 5'd5, 1'b0, 1'b0, 32'h0000_00AA, 32'h0, 32'h0, 16'h0);
    check_head("add", 5'd5, 32'h0000_00AA, 4'b1111);
    check("add.count", 32'(count), 32'd1);
    idle_cycle();
    check("add.count_after", 32'(count), 32'd0);
    check("add.wr_en_after", 32'(wr_en), 32'd0);

    // back-to-back with concurrent pop: count stays 1, head tracks newest
    push_one(OP_LB, 5'd3, 5'd9, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 16'h0);
    check_head("lb", 5'd3, 32'h0000_0078, 4'b0001);
    push_one(OP_LH, 5'd3, 5'd9, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 16'h0);
    check_head("lh", 5'd3, 32'h0000_5678, 4'b0011);
    check("lh.count", 32'(count), 32'd1);
    push_one(OP_LUI, 5'd4, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 16'hBEEF);
    check_head("lui", 5'd4, 32'hBEEF_0000, 4'b1111);
    push_one(OP_JAL, 5'd4, 5'd9, 1'b0, 1'b0, 32'h0, 32'h0, 32'hFFFF_FFFC, 16'h0);
    check_head("jal", 5'd31, 32'h0000_0000, 4'b1111);
    check("jal.count", 32'(count), 32'd1);
    // rt_rd and mem_sel select for a generic opcode
    push_one(OP_R, 5'd12, 5'd13, 1'b1, 1'b1, 32'h1111_1111, 32'hCAFE_F00D, 32'h0, 16'h0);
    check_head("rtsel", 5'd12, 32'hCAFE_F00D, 4'b1111);
    idle_cycle();
    check("rtsel.count_after", 32'(count), 32'd0);

    // fill under backpressure, then drain in order
    wr_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_one(OP_R, 5'd0, 5'(i), 1'b0, 1'b0, 32'h100 + 32'(i), 32'h0, 32'h0, 16'h0);
      exp_q.push_back({27'(32'h100 + 32'(i)), 5'(i)});
    end
    check("full.count", 32'(count), 32'd4);
    check("full.in_ready", 32'(in_ready), 32'd0);
    push_one(OP_R, 5'd0, 5'd9, 1'b0, 1'b0, 32'h999, 32'h0, 32'h0, 16'h0);
    check("refused.count", 32'(count), 32'd4);
    check("refused.head_addr", 32'(wr_addr), 32'd1);
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check("drain.wr_addr", 32'(wr_addr), 32'(e[4:0]));
      check("drain.wr_data", wr_data, 32'(e[31:5]));
      idle_cycle();
    end
    check("drain.count", 32'(count), 32'd0);
    check("drain.wr_en", 32'(wr_en), 32'd0);

    // forwarding: youngest r7 is a partial lb
    wr_ready = 1'b0;
    push_one(OP_R, 5'd0, 5'd7, 1'b0, 1'b0, 32'h0000_0011, 32'h0, 32'h0, 16'h0);
    fwd_addr = 5'd7; #1;
    check("fwd1.hit", 32'(fwd_hit), 32'd1);
    check("fwd1.partial", 32'(fwd_partial), 32'd0);
    check("fwd1.data", fwd_data, 32'h0000_0011);
    push_one(OP_LB, 5'd7, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0000_0022, 32'h0, 16'h0);
    check("fwd2.hit", 32'(fwd_hit), 32'd1);
    check("fwd2.partial", 32'(fwd_partial), 32'd1);
    check("fwd2.data", fwd_data, 32'h0000_0022);
    fwd_addr = 5'd0; #1;
    check("fwd0.hit", 32'(fwd_hit), 32'd0);
    check("fwd0.data", fwd_data, 32'h0);
    fwd_addr = 5'd9; #1;
    check("fwdmiss.hit", 32'(fwd_hit), 32'd0);
    check("fwdmiss.partial", 32'(fwd_partial), 32'd0);
    wr_ready = 1'b1;
    idle_cycle();
    wr_ready = 1'b0;
    fwd_addr = 5'd7; #1;
    check("fwdpop.partial", 32'(fwd_partial), 32'd1);
    check("fwdpop.count", 32'(count), 32'd1);
    wr_ready = 1'b1;
    idle_cycle();
    check("fwdgone.hit", 32'(fwd_hit), 32'd0);

    // write to r0: accepted, not queued
    check("r0.in_ready", 32'(in_ready), 32'd1);
    push_one(OP_R, 5'd0, 5'd0, 1'b0, 1'b0, 32'h5555_5555, 32'h0, 32'h0, 16'h0);
    check("r0.count", 32'(count), 32'd0);
    check("r0.wr_en", 32'(wr_en), 32'd0);

    // reset with three entries queued
    wr_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push_one(OP_R, 5'd0, 5'(20 + i), 1'b0, 1'b0, 32'(i), 32'h0, 32'h0, 16'h0);
    check("prerst.count", 32'(count), 32'd3);
    reset = 1'b1;
    idle_cycle();
    check("midrst.count", 32'(count), 32'd0);
    check("midrst.wr_en", 32'(wr_en), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("midrst.in_ready_after", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-back side of the register file: accepts completed results from the execute/memory stage, forms the destination address, data and byte mask per opcode, and buffers them in a small in-order queue. It drains one write per cycle into the register file's write port. A combinational forwarding port exposes pending results so operand reads do not see stale register contents. It sits between the execute/memory datapath and `Registers`, and replaces the ad-hoc `writeData`-triggered write path with a clocked handshake.

## Interface
- `DEPTH`, 4, queue entries (power of two, ≥2)
- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; flushes queue
- `in_valid`  in  1  result presented
- `in_ready`  out  1  queue can accept (count < DEPTH and not reset)
- `in_opcode`  in  6  instruction opcode
- `in_rt`, `in_rd`  in  5 each  destination candidates
- `in_rt_rd`  in  1  1 = write rt, 0 = write rd
- `in_mem_sel`  in  1  1 = data from `in_mem`, 0 = from `in_alu`
- `in_alu`, `in_mem`, `in_pc`  in  32 each  ALU result, load data, instruction PC
- `in_imm`  in  16  immediate field
- `wr_ready`  in  1  register file accepts a write this cycle
- `wr_en`  out  1  head entry valid (queue non-empty)
- `wr_addr`  out  5  head destination
- `wr_data`  out  32  head data
- `wr_mask`  out  4  head byte enables, bit i = byte i
- `fwd_addr`  in  5  register being read
- `fwd_hit`  out  1  a queued entry targets `fwd_addr`
- `fwd_partial`  out  1  youngest matching entry has mask ≠ 4'b1111
- `fwd_data`  out  32  youngest matching entry's data
- `count`  out  $clog2(DEPTH)+1  occupancy

## Operation
- Entry formation at accept (`in_valid && in_ready` at posedge):
  - lb (100000): addr = rt, data = {24'h0, in_mem[7:0]}, mask 0001
  - lh (100001): addr = rt, data = {16'h0, in_mem[15:0]}, mask 0011
  - lui (001111): addr = rt, data = {in_imm, 16'h0}, mask 1111
  - jal (000011): addr = 31, data = in_pc + 4 (mod 2^32), mask 1111
  - otherwise: addr = in_rt_rd ? rt : rd; data = in_mem_sel ? in_mem : in_alu; mask 1111
- An entry whose addr = 0 is accepted (handshake completes) but not enqueued.
- `wr_en` = count ≠ 0; `wr_*` driven combinationally from the head entry. Pop occurs at posedge when `wr_en && wr_ready`.
- Register file applies `wr_data` only to bytes enabled in `wr_mask` and preserves the rest.
- Forwarding: scan all valid entries; the youngest entry with addr = `fwd_addr` wins. `fwd_addr` = 0 gives `fwd_hit` = 0. When there is no hit, `fwd_partial` = 0 and `fwd_data` = 0. A consumer must stall while `fwd_partial` = 1.
- Order is strictly FIFO. Pointers wrap modulo DEPTH.

## Timing
- Reset values: count 0, pointers 0, `wr_en` 0, `fwd_hit` 0, `fwd_partial` 0, `in_ready` 0 while `reset` high and 1 in the first cycle after.
- Latency: accepted at edge N, so `wr_en` is high during cycle N→N+1, and the write completes at edge N+1 if `wr_ready` is high.
- Throughput is 1 accept and 1 write per cycle.
- Simultaneous push and pop: count is unchanged; legal when full only if the pop is known. `in_ready` does not depend on `wr_ready` (no pass-through), so a full queue refuses input that cycle.
- Empty queue: `wr_en` = 0. A push in the same cycle is not written until the next cycle.
- An entry accepted at edge N is visible to forwarding from cycle N→N+1 and stays visible until it is popped.
- Reset mid-operation: all queued writes are discarded. Nothing is written at the reset edge.

## Test plan
- Single add, rd = 5, alu = 0x0000_00AA, `wr_ready` = 1 → next cycle wr_en = 1, wr_addr = 5, wr_data = 0x0000_00AA, mask 1111; count returns to 0.
- lb rt = 3, in_mem = 0x1234_5678 → wr_data = 0x0000_0078, mask 0001. lh gives 0x0000_5678, mask 0011. lui imm = 0xBEEF gives 0xBEEF_0000.
- jal, pc = 0xFFFF_FFFC → wr_addr = 31, wr_data = 0x0000_0000 (wrap).
- `wr_ready` = 0, push 4 entries → count = 4, in_ready = 0. A fifth push is refused. Raise `wr_ready` → writes emerge in order, one per cycle.
- Queue holds r7 = 0x11 (full) then r7 = 0x22 via lb; fwd_addr = 7 → fwd_hit = 1, fwd_partial = 1, fwd_data = 0x22. fwd_addr = 0 → fwd_hit = 0.
- Write to rd = 0 → handshake completes, count stays 0. Assert `reset` with 3 entries queued → next cycle count = 0, wr_en = 0.
